uart_rx_ctrl: RTL and testbench

- Receive-side controller of the UART.
- Samples the serial line on an oversampling tick from the shared baud generator, detects and qualifies the start bit, and samples each data, parity and stop bit at mid-bit.
- Assembles the data LSB-first and presents the received word with a one-cycle valid pulse plus parity/framing status.
- Peer of the transmit-side bit selector; uses the same frame format (start, DATA_BITS, optional parity, one stop).

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_sync.sv | 29 ++
 rtl/uart_rx_ctrl.sv | 148 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: rx FSM states and
// frame line levels common to RX and TX.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// N-flop synchronizer for the serial line;
// resets to the idle line level.
module uart_rx_sync
  import uart_pkg::*;
#(
  parameter int N = 2
) (
  input  logic clk,
  input  logic arst_n,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [N-1:0] ff;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ff <= {N{IDLE_LVL}};
    end else if (rst) begin
      ff <= {N{IDLE_LVL}};
    end else begin
      ff <= {ff[N-2:0], d};
    end
  end

  assign q = ff[N-1];

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receiver: start qualification, mid-bit
// sampling, LSB-first assembly, parity/frame status.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 rst,
  input  logic                 rx_en,
  input  logic                 tick,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 busy,
  output logic                 parity_err,
  output logic                 frame_err
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  rx_state_t state, state_nxt;

  logic                 rxs;
  logic [CNT_W-1:0]     sample_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bad;
  logic                 line_ok;
  logic                 at_mid;
  logic                 at_end;
  logic                 last_bit;
  logic                 frame_done;

  uart_rx_sync #(
    .N(2)
  ) u_sync (
    .clk   (clk),
    .arst_n(arst_n),
    .rst   (rst),
    .d     (rx_in),
    .q     (rxs)
  );

  assign at_mid = tick &&
    (sample_cnt == CNT_W'(OVERSAMPLE/2 - 1));
  assign at_end = tick &&
    (sample_cnt == CNT_W'(OVERSAMPLE - 1));
  assign last_bit =
    (bit_cnt == BIT_W'(DATA_BITS - 1));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= IDLE;
    end else if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (tick && rxs == START_LVL && line_ok)
          state_nxt = START;
      end
      START: begin
        if (at_mid)
          state_nxt = (rxs == START_LVL) ? DATA : IDLE;
      end
      DATA: begin
        if (at_end && last_bit)
          state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
      end
      PARITY: begin
        if (at_end) state_nxt = STOP;
      end
      STOP: begin
        if (at_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!rx_en) state_nxt = IDLE;
  end

  always_comb begin
    busy       = (state != IDLE);
    frame_done = (state == STOP) && at_end && rx_en;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sample_cnt <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      par_bad    <= 1'b0;
      line_ok    <= 1'b1;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else if (rst) begin
      sample_cnt <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      par_bad    <= 1'b0;
      line_ok    <= 1'b1;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= frame_done;
      // counters restart on every state change
      if (state_nxt != state || !rx_en) begin
        sample_cnt <= '0;
        bit_cnt    <= '0;
      end else if (tick && state != IDLE) begin
        sample_cnt <= at_end ? '0 : sample_cnt + 1'b1;
        if (state == DATA && at_end)
          bit_cnt <= bit_cnt + 1'b1;
      end
      if (state == DATA && at_end && rx_en)
        shift_reg <= {rxs, shift_reg[DATA_BITS-1:1]};
      if (state == PARITY && at_end)
        par_bad <= (^{shift_reg, rxs}) !=
                   1'(PARITY_ODD);
      // a low stop bit blocks restart until idle
      if (frame_done && rxs != STOP_LVL)
        line_ok <= 1'b0;
      else if (state == IDLE && rxs == IDLE_LVL)
        line_ok <= 1'b1;
      if (frame_done) begin
        data_out   <= shift_reg;
        parity_err <= (PARITY_EN != 0) && par_bad;
        frame_err  <= (rxs != STOP_LVL);
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed scoreboard bench for uart_rx_ctrl
// with default parameters (8 data, even parity).
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       rst = 1'b0;
  logic       rx_en = 1'b0;
  logic       tick = 1'b0;
  logic       rx_in = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       busy;
  logic       parity_err;
  logic       frame_err;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;
  int   vcount = 0;

  uart_rx_ctrl #(
    .DATA_BITS (8),
    .OVERSAMPLE(16),
    .PARITY_EN (1),
    .PARITY_ODD(0)
  ) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .rst       (rst),
    .rx_en     (rx_en),
    .tick      (tick),
    .rx_in     (rx_in),
    .data_out  (data_out),
    .data_valid(data_valid),
    .busy      (busy),
    .parity_err(parity_err),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) tick = ~tick;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h",
                tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      exp_t e;
      vcount++;
      chk("busy_at_valid", 32'(busy), 0);
      if (sb.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("data_out", 32'(data_out), 32'(e.d));
        chk("parity_err", 32'(parity_err), 32'(e.pe));
        chk("frame_err", 32'(frame_err), 32'(e.fe));
      end
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!tick) @(posedge clk);
    end
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    wait_ticks(16);
  endtask

  task automatic send_frame(input logic [7:0] d,
                            input logic pbit,
                            input logic sbit);
    exp_t e;
    e.d  = d;
    e.pe = (pbit != ^d);
    e.fe = !sbit;
    sb.push_back(e);
    send_bit(1'b0);
    #1 chk("busy_in_frame", 32'(busy), 1);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(pbit);
    send_bit(sbit);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_data"}, 32'(data_out), 0);
    chk({tag, "_valid"}, 32'(data_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_perr"}, 32'(parity_err), 0);
    chk({tag, "_ferr"}, 32'(frame_err), 0);
  endtask

  initial begin
    repeat (4) @(posedge clk);
    #1 chk_reset_outs("reset");
    arst_n = 1'b1;
    rx_en  = 1'b1;
    wait_ticks(32);

    // clean frame
    send_frame(8'hA5, 1'b0, 1'b1);
    send_bit(1'b1);
    #1 chk("idle_after_a5", 32'(busy), 0);
    chk("vcount_a5", 32'(vcount), 1);

    // glitch on the line
    rx_in = 1'b0;
    wait_ticks(4);
    #1 chk("glitch_busy", 32'(busy), 1);
    rx_in = 1'b1;
    wait_ticks(12);
    #1 chk("glitch_idle", 32'(busy), 0);
    wait_ticks(16);
    chk("vcount_glitch", 32'(vcount), 1);

    // parity error
    send_frame(8'h3C, 1'b1, 1'b1);
    send_bit(1'b1);
    chk("vcount_3c", 32'(vcount), 2);

    // framing error then break
    send_frame(8'h00, 1'b0, 1'b0);
    wait_ticks(48);
    #1 chk("break_no_start", 32'(busy), 0);
    chk("vcount_break", 32'(vcount), 3);
    send_bit(1'b1);
    send_frame(8'h5A, 1'b0, 1'b1);
    send_bit(1'b1);
    chk("vcount_5a", 32'(vcount), 4);

    // abort during data bit 4
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rx_in = 1'b1;
    wait_ticks(8);
    rx_en = 1'b0;
    @(posedge clk);
    #1 chk("abort_busy", 32'(busy), 0);
    wait_ticks(48);
    chk("abort_vcount", 32'(vcount), 4);
    chk("abort_hold", 32'(data_out), 32'h5A);
    rx_en = 1'b1;
    wait_ticks(16);
    send_frame(8'h81, 1'b0, 1'b1);
    send_bit(1'b1);
    chk("vcount_81", 32'(vcount), 5);

    // back-to-back frames
    send_frame(8'h12, 1'b0, 1'b1);
    send_frame(8'h34, 1'b1, 1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("vcount_b2b", 32'(vcount), 7);
    #1 chk("b2b_busy", 32'(busy), 1);
    chk("b2b_data", 32'(data_out), 32'h34);

    // async reset mid-frame
    #3 arst_n = 1'b0;
    #1 chk_reset_outs("arst");
    rx_in = 1'b1;
    repeat (4) @(posedge clk);
    arst_n = 1'b1;
    wait_ticks(16);
    chk("sb_empty", 32'(sb.size()), 0);
    chk("vcount_final", 32'(vcount), 7);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
